game_timer: RTL and testbench
=============================

// Module: game_timer
// PURPOSE
//  Elapsed-game-time counter that produces the 4-digit BCD time_spent bus (MM:SS) consumed by
//  the VGA pixel generator for the in-game and game-over time readouts. Follows the top-level
//  screen state (menu/game/over): clears in menu, counts during game, freezes on game-over.
//  Sits between the top-level FSM and the pixel generator; one clock domain.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per counted second (sim benches use a small value, e.g. 4)
//  CNT_W     27           prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  state       in   2   screen state: 0=SMENU, 1=SGAME, 2=SOVER, 3=treated as SMENU
//  time_spent  out  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, each nibble 0..9 (sec_tens 0..5)
//  sec_tick    out  1   one-cycle pulse on each counted second
//  running     out  1   high while internal FSM is in T_RUN
//  overflow    out  1   sticky, set on saturation at 99:59 (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Reset: time_spent=16'h0000, sec_tick=0, running=0, overflow=0,
//    prescaler=0, FSM=T_IDLE. Reset mid-count wins over every other event.
//  - FSM states: T_IDLE (cleared), T_RUN (counting), T_HOLD (frozen).
//    T_IDLE: state==SGAME -> T_RUN, clear counts+prescaler on same edge.
//    T_RUN : state==SOVER -> T_HOLD; state==SMENU/3 -> T_IDLE with clear; else stay.
//    T_HOLD: state==SMENU/3 -> T_IDLE with clear; state==SGAME -> T_RUN with clear (new game);
//            else stay, time_spent held.
//  - Clear = time_spent, prescaler, overflow -> 0.
//  - Prescaler counts 0..TICK_DIV-1 only in T_RUN (FSM staying in T_RUN). On the edge where it
//    equals TICK_DIV-1: prescaler->0, time_spent increments, sec_tick=1 for exactly that next
//    cycle. First tick therefore arrives TICK_DIV cycles after entering T_RUN.
//  - Transition priority: an FSM transition out of T_RUN on the same edge as a wrap suppresses
//    the increment and sec_tick.
//  - BCD increment: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones;
//    min_ones 9->0 carries to min_tens; 99:59 handled per CONFIGURATION. No binary arithmetic
//    on the bus; nibbles never hold A..F.
//  - running = (FSM==T_RUN), updated on the same edge as the FSM.
// CONFIGURATION
//  GAME_TIMER_SAT_EN defined: at 99:59 a tick leaves time_spent at 16'h9959, still pulses
//    sec_tick, and sets overflow=1 until the next clear or rst.
//  GAME_TIMER_SAT_EN undefined: 99:59 + tick -> 16'h0000 (wrap), overflow tied 0.
// TESTING  (TICK_DIV=4)
//  1 rst high 3 cycles, state=SMENU -> time_spent=0000, sec_tick=0, running=0, overflow=0.
//  2 state=SGAME for 40 cycles -> running=1 next edge; sec_tick every 4th cycle; time_spent=0010
//    after 10 ticks (checks 09->10 carry); 60 ticks -> 0100.
//  3 preload to 09:59 by running 599 ticks, one more tick -> 1000; then SOVER -> running=0,
//    time_spent frozen at 1000 for 20 cycles, no sec_tick.
//  4 from T_HOLD set state=SGAME -> time_spent=0000 next edge, count restarts, first tick after
//    4 cycles; set state=3 mid-count -> T_IDLE, 0000.
//  5 state->SOVER on the exact wrap edge -> no increment, no sec_tick.
//  6 run to 99:59 then one tick: SAT_EN -> 9959, overflow=1, cleared by SMENU;
//    no macro -> 0000, overflow=0. Also assert rst mid-count -> all outputs reset next edge.

Source files
------------

// File: rtl/game_timer.sv
// Elapsed game time counter, BCD MM:SS, tracking the screen state (menu/game/over).
// Ports: clk, rst (sync, active high), state[1:0] in; time_spent[15:0], sec_tick, running,
// overflow out. Optional macro GAME_TIMER_SAT_EN: saturate at 99:59 with sticky overflow.
module game_timer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  output logic [15:0] time_spent,
  output logic        sec_tick,
  output logic        running,
  output logic        overflow
);

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_RUN  = 2'd1;
  localparam logic [1:0] T_HOLD = 2'd2;

  localparam logic [1:0] SGAME = 2'd1;
  localparam logic [1:0] SOVER = 2'd2;

  localparam logic [CNT_W-1:0] PRESC_MAX =
    CNT_W'(TICK_DIV - 1);

  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [15:0]      ts_q, ts_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;

  logic is_game, is_over, is_menu;
  logic clr;
  logic count_en;
  logic wrap;
  logic tick_en;
  logic sat_hit;
  logic [15:0] ts_inc;

  assign is_game = (state == SGAME);
  assign is_over = (state == SOVER);
  // Encoding 3 is treated as menu.
  assign is_menu = !is_game && !is_over;

  always_comb begin
    fsm_d = fsm_q;
    clr   = 1'b0;
    unique case (fsm_q)
      T_RUN: begin
        if (is_over) begin
          fsm_d = T_HOLD;
        end else if (is_menu) begin
          fsm_d = T_IDLE;
          clr   = 1'b1;
        end
      end
      T_HOLD: begin
        if (is_menu) begin
          fsm_d = T_IDLE;
          clr   = 1'b1;
        end else if (is_game) begin
          fsm_d = T_RUN;
          clr   = 1'b1;
        end
      end
      default: begin
        if (is_game) begin
          fsm_d = T_RUN;
          clr   = 1'b1;
        end
      end
    endcase
  end

  // Leaving T_RUN on a wrap edge suppresses the tick.
  assign count_en = (fsm_q == T_RUN) && (fsm_d == T_RUN);
  assign wrap     = (presc_q == PRESC_MAX);
  assign tick_en  = count_en && wrap;

  // Digit-wise BCD increment with ripple carry.
  always_comb begin
    ts_inc = ts_q;
    if (ts_q[3:0] != 4'd9) begin
      ts_inc[3:0] = ts_q[3:0] + 4'd1;
    end else begin
      ts_inc[3:0] = 4'd0;
      if (ts_q[7:4] != 4'd5) begin
        ts_inc[7:4] = ts_q[7:4] + 4'd1;
      end else begin
        ts_inc[7:4] = 4'd0;
        if (ts_q[11:8] != 4'd9) begin
          ts_inc[11:8] = ts_q[11:8] + 4'd1;
        end else begin
          ts_inc[11:8] = 4'd0;
          if (ts_q[15:12] != 4'd9) begin
            ts_inc[15:12] = ts_q[15:12] + 4'd1;
          end else begin
            ts_inc[15:12] = 4'd0;
          end
        end
      end
    end
  end

`ifdef GAME_TIMER_SAT_EN
  logic ovf_q, ovf_d;

  assign sat_hit = tick_en && (ts_q == 16'h9959);

  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (sat_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign sat_hit  = 1'b0;
  assign overflow = 1'b0;
`endif

  always_comb begin
    ts_d    = ts_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clr) begin
      ts_d    = 16'h0000;
      presc_d = '0;
    end else if (count_en) begin
      if (wrap) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // At saturation the value is held but the tick still pulses.
        if (!sat_hit) begin
          ts_d = ts_inc;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign run_d = (fsm_d == T_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= T_IDLE;
      presc_q <= '0;
      ts_q    <= 16'h0000;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      presc_q <= presc_d;
      ts_q    <= ts_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
    end
  end

  assign time_spent = ts_q;
  assign sec_tick   = tick_q;
  assign running    = run_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: vector table, corner sequences, random state traffic
// checked against an elapsed-seconds reference model.
module tb_game_timer;

  localparam int TD = 4;
`ifdef GAME_TIMER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [15:0] time_spent;
  logic        sec_tick;
  logic        running;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_timer #(
    .TICK_DIV(TD),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .time_spent(time_spent),
    .sec_tick  (sec_tick),
    .running   (running),
    .overflow  (overflow)
  );

  // Reference: mode 0=cleared, 1=counting, 2=frozen; seconds as an integer.
  int m_mode = 0;
  int m_secs = 0;
  int m_cyc  = 0;
  bit m_ovf  = 1'b0;
  bit m_tick = 1'b0;

  function automatic logic [15:0] to_bcd(input int secs);
    int mn, sc;
    mn = secs / 60;
    sc = secs % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic m_clear();
    m_secs = 0;
    m_cyc  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit r, input logic [1:0] s);
    bit g, o;
    g = (s == 2'd1);
    o = (s == 2'd2);
    m_tick = 1'b0;
    if (r) begin
      m_clear();
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (o) begin
        m_mode = 2;
      end else if (!g) begin
        m_clear();
        m_mode = 0;
      end else if (m_cyc == TD - 1) begin
        m_cyc  = 0;
        m_tick = 1'b1;
        if (m_secs == 5999) begin
          if (SAT) m_ovf = 1'b1;
          else m_secs = 0;
        end else begin
          m_secs++;
        end
      end else begin
        m_cyc++;
      end
    end else if (m_mode == 2) begin
      if (g) begin
        m_clear();
        m_mode = 1;
      end else if (!o) begin
        m_clear();
        m_mode = 0;
      end
    end else if (g) begin
      m_clear();
      m_mode = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input logic [1:0] s);
    rst   = r;
    state = s;
    @(posedge clk);
    model_step(r, s);
    #1;
    check("m_time", 32'(time_spent), 32'(to_bcd(m_secs)));
    check("m_tick", 32'(sec_tick), 32'(m_tick));
    check("m_run", 32'(running), 32'(m_mode == 1));
    check("m_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic run_n(input bit r, input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) cycle(r, s);
  endtask

  typedef struct {
    bit          r;
    logic [1:0]  s;
    int          n;
    logic [15:0] ts;
    bit          tick;
    bit          run;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int rv;
    logic [1:0] rs;

    rst   = 1'b1;
    state = 2'd0;

    tbl[0]  = '{1'b1, 2'd0, 3,   16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 1,   16'h0000, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 2'd1, 4,   16'h0001, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'd1, 36,  16'h0010, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'd1, 200, 16'h0100, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 2'd2, 1,   16'h0100, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd2, 20,  16'h0100, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1,   16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'd1, 3,   16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd1, 1,   16'h0001, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 2'd3, 1,   16'h0000, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      run_n(tbl[i].r, tbl[i].s, tbl[i].n);
      check($sformatf("vec%0d_time", i), 32'(time_spent), 32'(tbl[i].ts));
      check($sformatf("vec%0d_tick", i), 32'(sec_tick), 32'(tbl[i].tick));
      check($sformatf("vec%0d_run", i), 32'(running), 32'(tbl[i].run));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
    end

    // 09:59 -> 10:00, then freeze on game over.
    run_n(1'b0, 2'd1, 1 + 599 * TD);
    check("pre_0959", 32'(time_spent), 32'h0959);
    run_n(1'b0, 2'd1, TD);
    check("carry_1000", 32'(time_spent), 32'h1000);
    check("carry_tick", 32'(sec_tick), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 2'd2);
      check("hold_time", 32'(time_spent), 32'h1000);
      check("hold_tick", 32'(sec_tick), 32'd0);
      check("hold_run", 32'(running), 32'd0);
    end

    // Game over exactly on the wrap edge.
    run_n(1'b0, 2'd1, 1 + TD);
    check("pre_wrap", 32'(time_spent), 32'h0001);
    run_n(1'b0, 2'd1, TD - 1);
    cycle(1'b0, 2'd2);
    check("wrap_over_time", 32'(time_spent), 32'h0001);
    check("wrap_over_tick", 32'(sec_tick), 32'd0);
    check("wrap_over_run", 32'(running), 32'd0);

    // 99:59 boundary.
    run_n(1'b0, 2'd1, 1 + 5999 * TD);
    check("pre_9959", 32'(time_spent), 32'h9959);
    run_n(1'b0, 2'd1, TD);
    check("top_time", 32'(time_spent), SAT ? 32'h9959 : 32'h0000);
    check("top_ovf", 32'(overflow), 32'(SAT));
    check("top_tick", 32'(sec_tick), 32'd1);
    run_n(1'b0, 2'd1, TD);
    check("after_top_ovf", 32'(overflow), 32'(SAT));
    cycle(1'b0, 2'd0);
    check("menu_time", 32'(time_spent), 32'h0000);
    check("menu_ovf", 32'(overflow), 32'd0);

    // Reset mid-count.
    run_n(1'b0, 2'd1, 7);
    cycle(1'b1, 2'd1);
    check("rst_time", 32'(time_spent), 32'h0000);
    check("rst_tick", 32'(sec_tick), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    cycle(1'b0, 2'd1);
    check("rst_rerun", 32'(running), 32'd1);

    // Random screen-state traffic.
    for (int i = 0; i < 3000; i++) begin
      rv = int'($urandom_range(0, 99));
      if (rv < 70) rs = 2'd1;
      else if (rv < 80) rs = 2'd2;
      else if (rv < 90) rs = 2'd0;
      else rs = 2'd3;
      cycle($urandom_range(0, 199) == 0, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
